// File: rtl/vga_beat_overlay.sv
// Pixel-stream overlay for a beat-synchronised VGA display.
// Pixels pass from an Avalon-ST sink to a registered Avalon-ST source through
// a 2-entry skid buffer. Each accepted pixel is tagged with its frame position,
// and the pixel may be replaced by a white flash border (for a few frames after
// a beat) or by a red BPM bar along the bottom lines.
module vga_beat_overlay #(
   parameter int WIDTH        = 320,
   parameter int HEIGHT       = 240,
   parameter int BORDER       = 4,
   parameter int BAR_H        = 8,
   parameter int FLASH_FRAMES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  BPM_estimate,
   input  logic        beat_pulse,
   input  logic [29:0] snk_data,
   input  logic        snk_startofpacket,
   input  logic        snk_endofpacket,
   input  logic        snk_valid,
   output logic        snk_ready,
   output logic [29:0] src_data,
   output logic        src_startofpacket,
   output logic        src_endofpacket,
   output logic        src_valid,
   input  logic        src_ready
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_pending;
   logic [3:0]    r_flash;
   logic [8:0]    r_bpm;

   logic [29:0]   r_skid_data;
   logic          r_skid_sop;
   logic          r_skid_eop;
   logic          r_skid_valid;
   logic          r_snk_ready;

   logic [29:0]   r_src_data;
   logic          r_src_sop;
   logic          r_src_eop;
   logic          r_src_valid;

   logic          w_accept;
   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic          w_pend;
   logic          w_reload;
   logic [3:0]    w_flash;
   logic [8:0]    w_bpm;
   logic [31:0]   w_xi;
   logic [31:0]   w_yi;
   logic [31:0]   w_bpmi;
   logic [31:0]   w_bar_len;
   logic          w_border;
   logic          w_bar;
   logic [29:0]   w_pix;
   logic          w_out_free;
   logic          w_skid_nxt;

   assign snk_ready         = r_snk_ready;
   assign src_data          = r_src_data;
   assign src_startofpacket = r_src_sop;
   assign src_endofpacket   = r_src_eop;
   assign src_valid         = r_src_valid;

   assign w_accept = snk_valid & r_snk_ready;

   // A start-of-packet pixel is always (0,0) and samples tempo/flash state
   // for the frame it opens, so its own classification uses the fresh values.
   assign w_x      = snk_startofpacket ? '0 : r_x;
   assign w_y      = snk_startofpacket ? '0 : r_y;
   assign w_pend   = r_pending | beat_pulse;
   assign w_reload = w_accept & snk_startofpacket & w_pend;
   assign w_flash  = w_reload ? 4'(FLASH_FRAMES) : r_flash;
   assign w_bpm    = snk_startofpacket ? BPM_estimate : r_bpm;

   assign w_xi      = 32'(w_x);
   assign w_yi      = 32'(w_y);
   assign w_bpmi    = 32'(w_bpm);
   assign w_bar_len = (w_bpmi > WIDTH) ? WIDTH : w_bpmi;

   assign w_border = (w_xi < BORDER) || (w_xi >= WIDTH - BORDER) ||
                     (w_yi < BORDER) || (w_yi >= HEIGHT - BORDER);
   assign w_bar    = (w_yi >= HEIGHT - BAR_H) && (w_xi < w_bar_len);

   assign w_pix = (w_border && (w_flash != 4'd0)) ? 30'h3FFFFFFF :
                  w_bar                           ? {10'h3FF, 20'h0} :
                                                    snk_data;

   // Output register can take a new beat when empty or being drained this cycle.
   // The skid only fills when an accepted beat meets a stalled output.
   assign w_out_free = ~r_src_valid | src_ready;
   assign w_skid_nxt = w_out_free ? 1'b0 : (r_skid_valid | w_accept);

   // Output register and skid entry; snk_ready mirrors "skid will be empty".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_src_data   <= '0;
         r_src_sop    <= 1'b0;
         r_src_eop    <= 1'b0;
         r_src_valid  <= 1'b0;
         r_skid_data  <= '0;
         r_skid_sop   <= 1'b0;
         r_skid_eop   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_snk_ready  <= 1'b0;
      end else begin
         if (w_out_free) begin
            if (r_skid_valid) begin
               r_src_data  <= r_skid_data;
               r_src_sop   <= r_skid_sop;
               r_src_eop   <= r_skid_eop;
               r_src_valid <= 1'b1;
            end else if (w_accept) begin
               r_src_data  <= w_pix;
               r_src_sop   <= snk_startofpacket;
               r_src_eop   <= snk_endofpacket;
               r_src_valid <= 1'b1;
            end else begin
               r_src_valid <= 1'b0;
            end
         end else if (w_accept) begin
            r_skid_data <= w_pix;
            r_skid_sop  <= snk_startofpacket;
            r_skid_eop  <= snk_endofpacket;
         end
         r_skid_valid <= w_skid_nxt;
         r_snk_ready  <= ~w_skid_nxt;
      end
   end

   // Frame position, tempo sample and flash countdown advance only on acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_bpm   <= '0;
         r_flash <= '0;
      end else if (w_accept) begin
         if (w_x == XW'(WIDTH - 1)) begin
            r_x <= '0;
            r_y <= (w_y == YW'(HEIGHT - 1)) ? w_y : w_y + 1'b1;
         end else begin
            r_x <= w_x + 1'b1;
            r_y <= w_y;
         end
         r_bpm <= w_bpm;
         if (w_reload) begin
            r_flash <= 4'(FLASH_FRAMES);
         end else if (snk_endofpacket && (r_flash != 4'd0)) begin
            r_flash <= r_flash - 1'b1;
         end
      end
   end

   // Beat strobes are held until the next frame start consumes them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
      end else begin
         r_pending <= w_reload ? 1'b0 : w_pend;
      end
   end

endmodule

// File: tb/tb_vga_beat_overlay.sv
// Directed bench for vga_beat_overlay on a reduced 40x12 frame. A reference
// model computes each pixel's expected output when the sink accepts it and
// queues it; the queue is popped and compared as the source emits beats.
module tb_vga_beat_overlay;

   localparam int W  = 40;
   localparam int H  = 12;
   localparam int BD = 2;
   localparam int BH = 3;
   localparam int FF = 4;
   localparam int NP = W * H;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  bpm_in;
   logic        beat;
   logic [29:0] snk_data;
   logic        snk_sop, snk_eop, snk_valid;
   logic        snk_ready;
   logic [29:0] src_data;
   logic        src_sop, src_eop, src_valid;
   logic        src_ready;

   always #5 clk = ~clk;

   vga_beat_overlay #(
      .WIDTH(W), .HEIGHT(H), .BORDER(BD), .BAR_H(BH), .FLASH_FRAMES(FF)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .BPM_estimate(bpm_in),
      .beat_pulse(beat),
      .snk_data(snk_data),
      .snk_startofpacket(snk_sop),
      .snk_endofpacket(snk_eop),
      .snk_valid(snk_valid),
      .snk_ready(snk_ready),
      .src_data(src_data),
      .src_startofpacket(src_sop),
      .src_endofpacket(src_eop),
      .src_valid(src_valid),
      .src_ready(src_ready)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   int          m_nx, m_ny, m_flash, m_bpm;
   bit          m_pend;
   bit          held_v;
   logic [31:0] held;
   bit          rand_mode = 0;
   bit          gap_mode  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model and scoreboard, evaluated mid-cycle ahead of the next edge.
   always @(negedge clk) begin : model
      logic [31:0] obs, exp;
      logic [29:0] px;
      int          cx, cy, bl;
      bit          pend, rl, bdr, bar;
      if (!rst_n) begin
         sb_q.delete();
         m_nx = 0; m_ny = 0; m_flash = 0; m_bpm = 0; m_pend = 0; held_v = 0;
      end else begin
         obs = {src_sop, src_eop, src_data};
         if (held_v) chk("stall_hold", obs, held);
         if (src_valid && src_ready) begin
            chk("beat_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               exp = sb_q.pop_front();
               chk("pixel", obs, exp);
            end
         end
         held_v = src_valid && !src_ready;
         held   = obs;

         pend = m_pend | beat;
         if (snk_valid && snk_ready) begin
            rl = 0;
            if (snk_sop) begin
               cx = 0; cy = 0;
               m_bpm = int'(bpm_in);
               if (pend) begin m_flash = FF; pend = 0; rl = 1; end
            end else begin
               cx = m_nx; cy = m_ny;
            end
            bl  = (m_bpm > W) ? W : m_bpm;
            bdr = (cx < BD) || (cx >= W - BD) || (cy < BD) || (cy >= H - BD);
            bar = (cy >= H - BH) && (cx < bl);
            if (bdr && m_flash > 0) px = 30'h3FFFFFFF;
            else if (bar)           px = {10'h3FF, 20'h0};
            else                    px = snk_data;
            sb_q.push_back({snk_sop, snk_eop, px});
            m_nx = cx + 1; m_ny = cy;
            if (m_nx == W) begin
               m_nx = 0;
               m_ny = (cy + 1 < H) ? cy + 1 : H - 1;
            end
            if (snk_eop && !rl && m_flash > 0) m_flash--;
         end
         m_pend = pend;
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted it.
   task automatic send_pix(input logic [29:0] d, input bit s, input bit e,
                           input bit b, input logic [8:0] bpm);
      bit ok;
      int n;
      if (gap_mode && $urandom_range(0, 3) == 0) begin
         snk_valid = 1'b0;
         @(posedge clk); #1;
         if (rand_mode) src_ready = 1'($urandom_range(0, 1));
      end
      snk_data = d; snk_sop = s; snk_eop = e; snk_valid = 1'b1;
      beat = b; bpm_in = bpm;
      ok = 0; n = 0;
      while (!ok && n < 2000) begin
         @(negedge clk);
         ok = snk_ready;
         @(posedge clk); #1;
         beat = 1'b0;
         if (rand_mode) src_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk("accept_in_time", 32'(ok), 1);
   endtask

   task automatic send_frame(input int n, input bit sop0, input int inj, input int beat_at,
                             input int bpm_a, input int bpm_b, input int bpm_sw,
                             input bit lat_chk);
      for (int i = 0; i < n; i++) begin
         send_pix(30'($urandom), (i == 0 && sop0) || (i == inj), (i == n - 1),
                  (i == beat_at), 9'((i < bpm_sw) ? bpm_a : bpm_b));
         if (lat_chk && i == 0) begin
            chk("latency_valid", 32'(src_valid), 1);
            chk("latency_sop",   32'(src_sop), 1);
         end
      end
      snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
   endtask

   task automatic drain();
      int n;
      rand_mode = 0;
      src_ready = 1'b1;
      n = 0;
      while ((sb_q.size() != 0 || src_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain_queue_empty", 32'(sb_q.size()), 0);
   endtask

   initial begin
      rst_n = 1'b1;
      bpm_in = '0; beat = 1'b0;
      snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b0;
      src_ready = 1'b1;
      #1 rst_n = 1'b0;
      #22;
      chk("rst_src_valid", 32'(src_valid), 0);
      chk("rst_src_data",  32'(src_data), 0);
      chk("rst_src_sop",   32'(src_sop), 0);
      chk("rst_src_eop",   32'(src_eop), 0);
      chk("rst_snk_ready", 32'(snk_ready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("ready_low_before_edge", 32'(snk_ready), 0);
      @(posedge clk); #1;
      chk("ready_after_release", 32'(snk_ready), 1);

      // Clean frame, bar 25 wide, then a mid-frame beat and the four flashing frames.
      send_frame(NP, 1, -1, -1, 25, 25, 0, 1);
      send_frame(NP, 1, -1, 200, 25, 25, 0, 0);
      for (int f = 0; f < FF; f++) send_frame(NP, 1, -1, -1, 25, 25, 0, 0);
      // Clean again; tempo change mid-frame must not move the bar.
      send_frame(NP, 1, -1, -1, 10, 30, 100, 0);
      // Beat coincident with sop flashes that frame; oversized tempo clamps the bar.
      send_frame(NP, 1, -1, 0, 400, 400, 0, 0);
      drain();

      // Random backpressure and input gaps, injected sop, y saturation, sop-less frame.
      rand_mode = 1; gap_mode = 1;
      send_frame(700, 1, 100, -1, 30, 30, 0, 0);
      send_frame(200, 0, -1, -1, 30, 30, 0, 0);
      send_frame(NP, 1, -1, 50, 15, 15, 0, 0);
      send_frame(NP, 1, -1, -1, 35, 35, 0, 0);
      gap_mode = 0;
      drain();

      // Fill output register and skid, then reset mid-frame.
      for (int i = 0; i < 5; i++) send_pix(30'($urandom), (i == 0), 1'b0, 1'b0, 9'd20);
      src_ready = 1'b0;
      send_pix(30'($urandom), 1'b0, 1'b0, 1'b0, 9'd20);
      snk_valid = 1'b0;
      chk("skid_full_ready", 32'(snk_ready), 0);
      chk("skid_full_valid", 32'(src_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(src_valid), 0);
      chk("async_rst_data",  32'(src_data), 0);
      chk("async_rst_sop",   32'(src_sop), 0);
      chk("async_rst_eop",   32'(src_eop), 0);
      chk("async_rst_ready", 32'(snk_ready), 0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      src_ready = 1'b1;
      send_frame(NP, 1, -1, -1, 100, 100, 0, 1);
      drain();
      chk("idle_after_drain", 32'(src_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
